guess_round_sequencer: RTL and testbench
========================================

// Module: guess_round_sequencer
// PURPOSE
// - Round controller for the code-breaking game: owns the game FSM and sequences the datapath.
// - Latches the secret code from the LFSR and gates guess entry (key increments) and the checkers.
// - Counts tries in BCD and decides win/lose.
// - Sits between the board I/O (switch, debounced keys) and the checker/display/LED datapath.
// PARAMETERS
// - MAX_TRIES   10  guesses allowed per game (1..99); the MAX_TRIES-th non-winning score -> LOSE
// - CHECK_LAT   2   cycles check_en is held before counts are sampled (checker latency, >=1)
// - NPEGS       4   pegs per code
// - PEG_W       2   bits per peg (CODE_W = NPEGS*PEG_W = 8)
// PORTS
// - clk            in   1       system clock (single clock domain)
// - rst_n          in   1       reset: one clock; reset is asynchronous and active-low
// - start          in   1       one-cycle pulse: begin new game (any state)
// - submit         in   1       level (switch); a rising edge submits the current guess
// - lfsr_val       in   CODE_W  free-running random value from the LFSR
// - count_correct  in   3       checker: right colour, right place (0..4)
// - count_wrong    in   3       checker: right colour, wrong place (0..4)
// - sol_q          out  CODE_W  latched secret code fed to the checkers
// - entry_en       out  1       enables the guess-increment key inputs
// - check_en       out  1       enables the checkers
// - score_valid    out  1       one-cycle pulse when new results are latched
// - correct_q      out  3       latched count_correct of the last scored guess
// - wrong_q        out  3       latched count_wrong of the last scored guess
// - tries_ones     out  4       BCD ones digit of completed tries
// - tries_tens     out  4       BCD tens digit of completed tries
// - win            out  1       high while in WIN
// - lose           out  1       high while in LOSE
// BEHAVIOUR
// - Reset: state=IDLE; sol_q, correct_q, wrong_q, tries = 0; all 1-bit outputs 0.
//   The submit edge register resets to 1, so a switch already high at reset release is not a submit.
// - sub_edge = submit & ~submit_d. submit_d is updated every cycle in every state.
// - States: IDLE, ENTRY, CHECK, SCORE, WIN, LOSE.
// - start has priority over every other event in every state, including mid-CHECK (aborts the round).
//   - Next cycle: sol_q <= lfsr_val, tries/correct_q/wrong_q <= 0, state -> ENTRY.
// - IDLE: all enables low; sub_edge ignored.
// - ENTRY: entry_en=1.
//   - sub_edge -> CHECK; load the latency counter with CHECK_LAT-1.
// - CHECK: check_en=1, entry_en=0.
//   - Counter decrements each cycle; at 0 -> SCORE. CHECK lasts exactly CHECK_LAT cycles.
//   - sub_edge ignored.
// - SCORE: exactly one cycle.
//   - check_en stays 1 for this cycle.
//   - correct_q/wrong_q <= inputs; score_valid=1; tries increments.
//   - BCD increment: ones 9 -> 0 with tens+1; saturates at 99.
//   - Next state:
//     - count_correct >= NPEGS -> WIN
//     - else post-increment tries == MAX_TRIES -> LOSE
//     - else -> ENTRY
//   - A submit still held high does not resubmit; a new rising edge is required.
// - WIN / LOSE: terminal.
//   - win or lose held at 1; results and tries frozen.
//   - Only start leaves these states.
// - Latency: submit rising edge in ENTRY to score_valid = CHECK_LAT+2 cycles.
//   - +1 cycle to enter CHECK, +CHECK_LAT cycles in CHECK, then SCORE.
// - Outputs are registered or pure decodes of the state register; no combinational path from inputs.
// STRUCTURE
// - Shared package game_pkg holds:
//   - game_state_t enum
//   - NPEGS, PEG_W, CODE_W
//   - BCD digit typedef
// - Sub-module bcd_tries_counter: two-digit BCD counter with sync clear, inc and saturation at 99.
// - Everything else (FSM, edge detect, latency counter, result latches) lives in this module.
// TESTING
// - Reset release with submit=1, then start with lfsr_val=8'hB4 -> ENTRY, sol_q=B4.
//   No CHECK until submit falls and rises again.
// - ENTRY, submit rising edge, CHECK_LAT=2:
//   check_en high 3 cycles, score_valid pulses 4 cycles after the edge.
//   count_correct=2, count_wrong=1 -> correct_q=2, wrong_q=1, tries=01, back to ENTRY.
// - count_correct=4 at SCORE -> WIN.
//   win=1; further submits ignored; tries frozen.
// - MAX_TRIES=10, ten non-winning scores -> tries=10 (tens=1, ones=0), LOSE, lose=1.
// - start pulse during CHECK -> ENTRY next cycle; no score_valid; tries=00; new sol_q latched.
// - rst_n asserted mid-CHECK -> IDLE immediately (async); all outputs 0.
//   Tries counter with MAX_TRIES=99 saturates at 99.

Source files
------------

// File: rtl/guess_round_sequencer_pkg.sv
// Shared game package for the code-breaking round controller.
// Holds the game state encoding, code geometry (NPEGS, PEG_W, CODE_W),
// the BCD digit type and a helper that turns two BCD digits into binary.
package guess_round_sequencer_pkg;

  localparam int NPEGS  = 4;
  localparam int PEG_W  = 2;
  localparam int CODE_W = NPEGS * PEG_W;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_CHECK = 3'd2,
    ST_SCORE = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } game_state_t;

  // Two BCD digits (00..99) to a 7-bit binary value.
  function automatic logic [6:0] bcd_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
    return ({3'd0, tens} * 7'd10) + {3'd0, ones};
  endfunction

endpackage

// File: rtl/guess_round_sequencer_if.sv
// Board-side bus of the round controller.
// i_* : start pulse, submit switch level, LFSR value, checker counts.
// o_* : latched secret, entry/check enables, score pulse, latched counts,
//       BCD tries digits, win/lose flags.
// master = board/datapath side, slave = the sequencer.
interface guess_round_sequencer_if;
  import guess_round_sequencer_pkg::*;

  logic              i_start;
  logic              i_submit;
  logic [CODE_W-1:0] i_lfsr_val;
  logic [2:0]        i_count_correct;
  logic [2:0]        i_count_wrong;

  logic [CODE_W-1:0] o_sol_q;
  logic              o_entry_en;
  logic              o_check_en;
  logic              o_score_valid;
  logic [2:0]        o_correct_q;
  logic [2:0]        o_wrong_q;
  bcd_digit_t        o_tries_ones;
  bcd_digit_t        o_tries_tens;
  logic              o_win;
  logic              o_lose;

  modport master (
    output i_start, i_submit, i_lfsr_val, i_count_correct, i_count_wrong,
    input  o_sol_q, o_entry_en, o_check_en, o_score_valid, o_correct_q,
           o_wrong_q, o_tries_ones, o_tries_tens, o_win, o_lose
  );

  modport slave (
    input  i_start, i_submit, i_lfsr_val, i_count_correct, i_count_wrong,
    output o_sol_q, o_entry_en, o_check_en, o_score_valid, o_correct_q,
           o_wrong_q, o_tries_ones, o_tries_tens, o_win, o_lose
  );

endinterface

// File: rtl/guess_round_sequencer_bcd_tries_counter.sv
// Two-digit BCD tries counter.
// Ports: clk, rst_n (async active-low), i_clr (sync clear, wins over inc),
//        i_inc (count one try), o_ones / o_tens (BCD digits, saturate at 99).
module guess_round_sequencer_bcd_tries_counter
  import guess_round_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output bcd_digit_t o_ones,
  output bcd_digit_t o_tens
);

  bcd_digit_t r_ones;
  bcd_digit_t r_tens;

  // Digit registers: clear, BCD increment with carry, hold at 99.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (i_clr) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else if (i_inc) begin
      if (r_ones == 4'd9 && r_tens == 4'd9) begin
        r_ones <= r_ones;
        r_tens <= r_tens;
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
        r_tens <= r_tens;
      end
    end else begin
      r_ones <= r_ones;
      r_tens <= r_tens;
    end
  end

  assign o_ones = r_ones;
  assign o_tens = r_tens;

endmodule

// File: rtl/guess_round_sequencer.sv
// Round controller of the code-breaking game.
// Owns the game FSM, latches the secret code from the LFSR, gates guess entry
// and the checkers, latches the checker results, counts tries in BCD and
// decides win/lose.
// Ports: clk, rst_n (async active-low), bus (slave side of
//        guess_round_sequencer_if). All bus outputs are registered.
module guess_round_sequencer
  import guess_round_sequencer_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int CHECK_LAT = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  guess_round_sequencer_if.slave bus
);

  localparam int LAT_W = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

  game_state_t       r_state;
  game_state_t       w_state_nxt;
  logic              r_submit_d;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [CODE_W-1:0] r_sol_q;
  logic [2:0]        r_correct_q;
  logic [2:0]        r_wrong_q;
  logic              r_score_valid;
  logic              r_entry_en;
  logic              r_check_en;
  logic              r_win;
  logic              r_lose;
  logic              w_sub_edge;
  logic              w_tries_inc;
  bcd_digit_t        w_ones;
  bcd_digit_t        w_tens;
  logic [6:0]        w_tries_bin;

  assign w_sub_edge  = bus.i_submit & ~r_submit_d;
  assign w_tries_inc = ~bus.i_start & (r_state == ST_SCORE);
  assign w_tries_bin = bcd_to_bin(w_tens, w_ones);

  guess_round_sequencer_bcd_tries_counter u_tries (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (bus.i_start),
    .i_inc  (w_tries_inc),
    .o_ones (w_ones),
    .o_tens (w_tens)
  );

  // Next-state decision; start overrides everything, including an open CHECK.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_start) begin
      w_state_nxt = ST_ENTRY;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_ENTRY: begin
          if (w_sub_edge) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_ENTRY;
          end
        end
        ST_CHECK: begin
          if (r_lat_cnt == '0) begin
            w_state_nxt = ST_SCORE;
          end else begin
            w_state_nxt = ST_CHECK;
          end
        end
        // Lose test uses the try being counted now (post-increment value).
        ST_SCORE: begin
          if (bus.i_count_correct >= 3'(NPEGS)) begin
            w_state_nxt = ST_WIN;
          end else if (w_tries_bin + 7'd1 == 7'(MAX_TRIES)) begin
            w_state_nxt = ST_LOSE;
          end else begin
            w_state_nxt = ST_ENTRY;
          end
        end
        ST_WIN:   w_state_nxt = ST_WIN;
        ST_LOSE:  w_state_nxt = ST_LOSE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, edge register, latency counter, result latches and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_submit_d    <= 1'b1;  // a switch already high at reset release is not a submit
      r_lat_cnt     <= '0;
      r_sol_q       <= '0;
      r_correct_q   <= 3'd0;
      r_wrong_q     <= 3'd0;
      r_score_valid <= 1'b0;
      r_entry_en    <= 1'b0;
      r_check_en    <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_submit_d <= bus.i_submit;

      // CHECK lasts CHECK_LAT cycles: load CHECK_LAT-1 on entry, leave at 0.
      if (w_state_nxt == ST_CHECK && r_state != ST_CHECK) begin
        r_lat_cnt <= LAT_W'(CHECK_LAT - 1);
      end else if (r_state == ST_CHECK && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end else begin
        r_lat_cnt <= r_lat_cnt;
      end

      if (bus.i_start) begin
        r_sol_q     <= bus.i_lfsr_val;
        r_correct_q <= 3'd0;
        r_wrong_q   <= 3'd0;
      end else if (r_state == ST_SCORE) begin
        r_sol_q     <= r_sol_q;
        r_correct_q <= bus.i_count_correct;
        r_wrong_q   <= bus.i_count_wrong;
      end else begin
        r_sol_q     <= r_sol_q;
        r_correct_q <= r_correct_q;
        r_wrong_q   <= r_wrong_q;
      end

      // Flags follow the state being entered so they line up with r_state.
      r_score_valid <= w_tries_inc;
      r_entry_en    <= (w_state_nxt == ST_ENTRY);
      r_check_en    <= (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_SCORE);
      r_win         <= (w_state_nxt == ST_WIN);
      r_lose        <= (w_state_nxt == ST_LOSE);
    end
  end

  assign bus.o_sol_q       = r_sol_q;
  assign bus.o_entry_en    = r_entry_en;
  assign bus.o_check_en    = r_check_en;
  assign bus.o_score_valid = r_score_valid;
  assign bus.o_correct_q   = r_correct_q;
  assign bus.o_wrong_q     = r_wrong_q;
  assign bus.o_tries_ones  = w_ones;
  assign bus.o_tries_tens  = w_tens;
  assign bus.o_win         = r_win;
  assign bus.o_lose        = r_lose;

endmodule

// File: tb/tb_guess_round_sequencer.sv
// Directed bench for guess_round_sequencer: one instance with MAX_TRIES=10,
// a second with MAX_TRIES=99, both CHECK_LAT=2 on a shared clock and reset.
module tb_guess_round_sequencer;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  guess_round_sequencer_if bus ();
  guess_round_sequencer_if bus99 ();

  guess_round_sequencer #(.MAX_TRIES(10), .CHECK_LAT(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  guess_round_sequencer #(.MAX_TRIES(99), .CHECK_LAT(2)) u_dut99 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus99)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One guess: drop submit, raise it, then 4 cycles until the score is latched.
  task automatic round(input bit b99, input logic [2:0] cc, input logic [2:0] cw);
    if (b99) bus99.i_submit = 1'b0; else bus.i_submit = 1'b0;
    tick();
    if (b99) begin
      bus99.i_submit = 1'b1; bus99.i_count_correct = cc; bus99.i_count_wrong = cw;
    end else begin
      bus.i_submit = 1'b1; bus.i_count_correct = cc; bus.i_count_wrong = cw;
    end
    repeat (4) tick();
  endtask

  task automatic pulse_start(input logic [7:0] val);
    bus.i_start = 1'b1;
    bus.i_lfsr_val = val;
    tick();
    bus.i_start = 1'b0;
  endtask

  initial begin
    logic [3:0] ce_seen;
    logic [3:0] sv_seen;
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_submit = 1'b1; bus.i_lfsr_val = 8'h00;
    bus.i_count_correct = 3'd0; bus.i_count_wrong = 3'd0;
    bus99.i_start = 1'b0; bus99.i_submit = 1'b0; bus99.i_lfsr_val = 8'h00;
    bus99.i_count_correct = 3'd0; bus99.i_count_wrong = 3'd0;
    repeat (2) tick();

    // Reset state
    chk("rst_sol", {24'd0, bus.o_sol_q}, 32'h00);
    chk("rst_flags", {26'd0, bus.o_entry_en, bus.o_check_en, bus.o_score_valid,
                      bus.o_win, bus.o_lose, 1'b0}, 32'd0);
    chk("rst_tries", {24'd0, bus.o_tries_tens, bus.o_tries_ones}, 32'h00);

    // Release with submit held high: stays IDLE, then start latches the code
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_entry_en", {31'd0, bus.o_entry_en}, 32'd0);
    pulse_start(8'hB4);
    chk("start_entry_en", {31'd0, bus.o_entry_en}, 32'd1);
    chk("start_sol", {24'd0, bus.o_sol_q}, 32'hB4);
    repeat (3) tick();
    chk("held_submit_no_check", {31'd0, bus.o_check_en}, 32'd0);

    // First guess: check_en for 3 cycles, score_valid on the 4th edge
    bus.i_submit = 1'b0;
    tick();
    bus.i_submit = 1'b1; bus.i_count_correct = 3'd2; bus.i_count_wrong = 3'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      ce_seen[k] = bus.o_check_en;
      sv_seen[k] = bus.o_score_valid;
    end
    chk("check_en_window", {28'd0, ce_seen}, 32'b0111);
    chk("score_valid_lat", {28'd0, sv_seen}, 32'b1000);
    chk("correct_q", {29'd0, bus.o_correct_q}, 32'd2);
    chk("wrong_q", {29'd0, bus.o_wrong_q}, 32'd1);
    chk("tries_01", {24'd0, bus.o_tries_tens, bus.o_tries_ones}, 32'h01);
    chk("back_entry", {31'd0, bus.o_entry_en}, 32'd1);
    tick();
    chk("score_pulse_1cyc", {31'd0, bus.o_score_valid}, 32'd0);
    repeat (2) tick();
    chk("no_resubmit", {31'd0, bus.o_check_en}, 32'd0);

    // Winning guess, then further submits are ignored
    round(1'b0, 3'd4, 3'd0);
    chk("win", {30'd0, bus.o_win, bus.o_lose}, 32'b10);
    chk("win_tries", {24'd0, bus.o_tries_tens, bus.o_tries_ones}, 32'h02);
    round(1'b0, 3'd1, 3'd2);
    chk("win_frozen", {22'd0, bus.o_win, bus.o_check_en, bus.o_correct_q,
                       bus.o_tries_ones}, {22'd0, 1'b1, 1'b0, 3'd4, 4'd2});

    // Ten non-winning guesses lose
    pulse_start(8'h21);
    chk("new_game_tries", {24'd0, bus.o_tries_tens, bus.o_tries_ones}, 32'h00);
    for (int r = 0; r < 9; r++) round(1'b0, 3'd1, 3'd0);
    chk("tries_09", {23'd0, bus.o_entry_en, bus.o_tries_tens, bus.o_tries_ones}, 32'h109);
    round(1'b0, 3'd3, 3'd1);
    chk("tries_10", {24'd0, bus.o_tries_tens, bus.o_tries_ones}, 32'h10);
    chk("lose", {30'd0, bus.o_win, bus.o_lose}, 32'b01);

    // start during CHECK aborts the round
    pulse_start(8'h5A);
    round(1'b0, 3'd2, 3'd2);
    chk("pre_abort_tries", {24'd0, bus.o_tries_tens, bus.o_tries_ones}, 32'h01);
    bus.i_submit = 1'b0;
    tick();
    bus.i_submit = 1'b1;
    tick();
    chk("in_check", {31'd0, bus.o_check_en}, 32'd1);
    pulse_start(8'h3C);
    chk("abort_state", {30'd0, bus.o_entry_en, bus.o_check_en}, 32'b10);
    chk("abort_sol_tries", {16'd0, bus.o_sol_q, bus.o_tries_tens, bus.o_tries_ones},
        32'h3C00);
    sv_seen = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      sv_seen[k] = bus.o_score_valid;
    end
    chk("abort_no_score", {28'd0, sv_seen}, 32'd0);

    // Async reset in the middle of CHECK
    bus.i_submit = 1'b0;
    tick();
    bus.i_submit = 1'b1;
    tick();
    chk("pre_rst_check", {31'd0, bus.o_check_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {27'd0, bus.o_entry_en, bus.o_check_en, bus.o_score_valid,
                            bus.o_win, bus.o_lose}, 32'd0);
    chk("async_rst_data", {16'd0, bus.o_sol_q, bus.o_tries_tens, bus.o_tries_ones},
        32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // MAX_TRIES=99 instance counts all the way to 99
    bus99.i_start = 1'b1; bus99.i_lfsr_val = 8'h77;
    tick();
    bus99.i_start = 1'b0;
    for (int r = 0; r < 98; r++) round(1'b1, 3'd0, 3'd1);
    chk("tries_98", {23'd0, bus99.o_entry_en, bus99.o_tries_tens, bus99.o_tries_ones},
        32'h198);
    round(1'b1, 3'd2, 3'd0);
    chk("tries_99", {24'd0, bus99.o_tries_tens, bus99.o_tries_ones}, 32'h99);
    chk("lose_99", {30'd0, bus99.o_win, bus99.o_lose}, 32'b01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
